// File: rtl/reorder_buffer_if.sv
// Signal bundle between the reorder buffer and its decoder, CDB, operand-query and commit clients.
interface reorder_buffer_if #(
  parameter int TAG_W  = 4,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [REG_W-1:0]  alloc_dest;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  qry_tag1;
  logic [TAG_W-1:0]  qry_tag2;
  logic              qry_ready1;
  logic              qry_ready2;
  logic [DATA_W-1:0] qry_data1;
  logic [DATA_W-1:0] qry_data2;
  logic              commit_en;
  logic [REG_W-1:0]  commit_name;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;

  modport master (
    output alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, qry_tag1, qry_tag2,
    input  alloc_ready, alloc_tag, qry_ready1, qry_ready2, qry_data1, qry_data2,
    input  commit_en, commit_name, commit_data, commit_tag
  );

  modport slave (
    input  alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, qry_tag1, qry_tag2,
    output alloc_ready, alloc_tag, qry_ready1, qry_ready2, qry_data1, qry_data2,
    output commit_en, commit_name, commit_data, commit_tag
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation, CDB result capture, one in-order commit per cycle.
// Optional macro ROB_QUERY_BYPASS_EN: operand queries also see an accepted same-cycle CDB write.
module reorder_buffer #(
  parameter int               DEPTH    = 8,
  parameter int               TAG_W    = 4,
  parameter logic [TAG_W-1:0] TAG_FREE = {TAG_W{1'b1}},
  parameter int               REG_W    = 5,
  parameter int               DATA_W   = 32
) (
  input logic             clk,
  input logic             rst_n,
  reorder_buffer_if.slave bus
);
  localparam int               IDX_W     = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] DEPTH_TAG = TAG_W'(DEPTH);

  logic [IDX_W-1:0]  head_reg;
  logic [IDX_W-1:0]  tail_reg;
  logic [IDX_W:0]    count_reg;
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  valid_next;
  logic [DEPTH-1:0]  ready_reg;
  logic [DEPTH-1:0]  ready_next;
  logic [REG_W-1:0]  dest_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              commit_en_reg;
  logic [REG_W-1:0]  commit_name_reg;
  logic [DATA_W-1:0] commit_data_reg;
  logic [TAG_W-1:0]  commit_tag_reg;

  logic              alloc_ready;
  logic              alloc_fire;
  logic              commit_fire;
  logic              cdb_hit;
  logic [IDX_W-1:0]  cdb_idx;

  // Fullness uses the count at the start of the cycle, so a same-cycle commit cannot free a slot.
  assign alloc_ready = (count_reg < (IDX_W+1)'(DEPTH));
  assign alloc_fire  = bus.alloc_valid && alloc_ready;
  assign commit_fire = valid_reg[head_reg] && ready_reg[head_reg];
  assign cdb_idx     = bus.cdb_tag[IDX_W-1:0];
  assign cdb_hit     = bus.cdb_valid && (bus.cdb_tag != TAG_FREE) &&
                       (bus.cdb_tag < DEPTH_TAG) && valid_reg[cdb_idx];

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_tag   = TAG_W'(tail_reg);
  assign bus.commit_en   = commit_en_reg;
  assign bus.commit_name = commit_name_reg;
  assign bus.commit_data = commit_data_reg;
  assign bus.commit_tag  = commit_tag_reg;

  // Alloc hits only an invalid slot and commit only the valid head, so they never collide.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic take;
      logic retire;
      logic wb;
      assign take   = alloc_fire && (tail_reg == IDX_W'(gi));
      assign retire = commit_fire && (head_reg == IDX_W'(gi));
      assign wb     = cdb_hit && (cdb_idx == IDX_W'(gi));
      assign valid_next[gi] = take ? 1'b1 : (retire ? 1'b0 : valid_reg[gi]);
      assign ready_next[gi] = (take || retire) ? 1'b0 : (wb ? 1'b1 : ready_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      valid_reg       <= '0;
      ready_reg       <= '0;
      commit_en_reg   <= 1'b0;
      commit_name_reg <= '0;
      commit_data_reg <= '0;
      commit_tag_reg  <= TAG_FREE;
    end else begin
      valid_reg     <= valid_next;
      ready_reg     <= ready_next;
      commit_en_reg <= commit_fire;
      count_reg     <= count_reg + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
      if (alloc_fire) begin
        tail_reg <= tail_reg + IDX_W'(1);
      end
      if (commit_fire) begin
        head_reg        <= head_reg + IDX_W'(1);
        commit_name_reg <= dest_mem[head_reg];
        commit_data_reg <= data_mem[head_reg];
        commit_tag_reg  <= TAG_W'(head_reg);
      end
    end
  end

  // Payload storage needs no reset: it is only observed through valid/ready.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      dest_mem[tail_reg] <= bus.alloc_dest;
    end
    if (cdb_hit) begin
      data_mem[cdb_idx] <= bus.cdb_data;
    end
  end

  logic [TAG_W-1:0]  qry_tag   [2];
  logic              qry_ready [2];
  logic [DATA_W-1:0] qry_data  [2];

  assign qry_tag[0]     = bus.qry_tag1;
  assign qry_tag[1]     = bus.qry_tag2;
  assign bus.qry_ready1 = qry_ready[0];
  assign bus.qry_ready2 = qry_ready[1];
  assign bus.qry_data1  = qry_data[0];
  assign bus.qry_data2  = qry_data[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_qry
      logic [IDX_W-1:0] idx;
      logic             stored;
      assign idx    = qry_tag[gi][IDX_W-1:0];
      assign stored = (qry_tag[gi] != TAG_FREE) && (qry_tag[gi] < DEPTH_TAG) &&
                      valid_reg[idx] && ready_reg[idx];
`ifdef ROB_QUERY_BYPASS_EN
      logic bypass;
      assign bypass        = cdb_hit && (bus.cdb_tag == qry_tag[gi]);
      assign qry_ready[gi] = bypass || stored;
      assign qry_data[gi]  = bypass ? bus.cdb_data : (stored ? data_mem[idx] : '0);
`else
      assign qry_ready[gi] = stored;
      assign qry_data[gi]  = stored ? data_mem[idx] : '0;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized self-checking bench for reorder_buffer against a program-order queue model.
module tb_reorder_buffer;
  localparam int         DEPTH    = 8;
  localparam logic [3:0] TAG_FREE = 4'hF;

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  dest;
    bit          done;
    logic [31:0] data;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.TAG_W(4), .REG_W(5), .DATA_W(32)) bus ();

  reorder_buffer #(
    .DEPTH(DEPTH), .TAG_W(4), .TAG_FREE(TAG_FREE), .REG_W(5), .DATA_W(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: in-flight instructions in program order, oldest first.
  ent_t        q[$];
  int          next_tag;
  logic        exp_en;
  logic [4:0]  exp_name;
  logic [31:0] exp_data;
  logic [3:0]  exp_ctag;

  task automatic model_reset();
    q.delete();
    next_tag = 0;
    exp_en   = 1'b0;
    exp_name = '0;
    exp_data = '0;
    exp_ctag = TAG_FREE;
  endtask

  function automatic int find(input logic [3:0] t);
    foreach (q[i]) if (q[i].tag == t) return i;
    return -1;
  endfunction

  function automatic logic [32:0] lookup(input logic [3:0] t);
    int          i = find(t);
    logic [32:0] r = '0;
    if (i >= 0 && q[i].done) r = {1'b1, q[i].data};
`ifdef ROB_QUERY_BYPASS_EN
    if (bus.cdb_valid && find(bus.cdb_tag) >= 0 && bus.cdb_tag == t) r = {1'b1, bus.cdb_data};
`endif
    return r;
  endfunction

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cycle();
    logic [32:0] l1;
    logic [32:0] l2;
    bit          fire;
    bit          alloc_ok;
    int          ci;
    #1;
    check("alloc_ready", bus.alloc_ready, q.size() < DEPTH);
    check("alloc_tag", bus.alloc_tag, next_tag);
    l1 = lookup(bus.qry_tag1);
    l2 = lookup(bus.qry_tag2);
    check("qry_ready1", bus.qry_ready1, l1[32]);
    check("qry_data1", bus.qry_data1, l1[31:0]);
    check("qry_ready2", bus.qry_ready2, l2[32]);
    check("qry_data2", bus.qry_data2, l2[31:0]);
    alloc_ok = bus.alloc_valid && (q.size() < DEPTH);
    fire     = (q.size() > 0) && q[0].done;
    if (fire) begin
      exp_en   = 1'b1;
      exp_name = q[0].dest;
      exp_data = q[0].data;
      exp_ctag = q[0].tag;
    end else begin
      exp_en = 1'b0;
    end
    ci = bus.cdb_valid ? find(bus.cdb_tag) : -1;
    if (ci >= 0) begin
      q[ci].done = 1'b1;
      q[ci].data = bus.cdb_data;
    end
    if (fire) void'(q.pop_front());
    if (alloc_ok) begin
      q.push_back('{4'(next_tag), bus.alloc_dest, 1'b0, 32'h0});
      next_tag = (next_tag + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    check("commit_en", bus.commit_en, exp_en);
    check("commit_name", bus.commit_name, exp_name);
    check("commit_data", bus.commit_data, exp_data);
    check("commit_tag", bus.commit_tag, exp_ctag);
    if (bus.commit_en)
      $display("commit tag=%0d r%0d data=%h", bus.commit_tag, bus.commit_name, bus.commit_data);
  endtask

  task automatic set_idle();
    bus.alloc_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
  endtask

  task automatic do_alloc(input logic [4:0] d);
    set_idle();
    bus.alloc_valid = 1'b1;
    bus.alloc_dest  = d;
    cycle();
  endtask

  task automatic do_cdb(input logic [3:0] t, input logic [31:0] d);
    set_idle();
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
    cycle();
  endtask

  task automatic idle_cycle();
    set_idle();
    cycle();
  endtask

  initial begin
    logic [3:0] tags[$];
    bus.alloc_valid = 1'b0;
    bus.alloc_dest  = '0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_data    = '0;
    bus.qry_tag1    = '0;
    bus.qry_tag2    = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_commit_en", bus.commit_en, 1'b0);
    check("rst_commit_tag", bus.commit_tag, 4'hF);
    check("rst_alloc_ready", bus.alloc_ready, 1'b1);
    check("rst_alloc_tag", bus.alloc_tag, 4'h0);
    check("rst_qry_ready1", bus.qry_ready1, 1'b0);

    // In-order retire
    do_alloc(5'd5);
    do_alloc(5'd6);
    do_alloc(5'd7);
    do_cdb(4'd1, 32'h22);
    do_cdb(4'd0, 32'h11);
    idle_cycle();
    check("io_first_name", bus.commit_name, 5'd5);
    check("io_first_data", bus.commit_data, 32'h11);
    idle_cycle();
    check("io_second_tag", bus.commit_tag, 4'd1);
    idle_cycle();
    check("io_stall_en", bus.commit_en, 1'b0);
    do_cdb(4'd2, 32'h33);
    idle_cycle();
    idle_cycle();

    // Full and wrap
    repeat (DEPTH) do_alloc(5'($urandom_range(31)));
    check("full_alloc_ready", bus.alloc_ready, 1'b0);
    set_idle();
    bus.alloc_valid = 1'b1;
    cycle();
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = q[0].tag;
    bus.cdb_data  = $urandom;
    cycle();
    bus.cdb_valid = 1'b0;
    cycle();
    cycle();
    tags.delete();
    foreach (q[i]) tags.push_back(q[i].tag);
    foreach (tags[i]) do_cdb(tags[i], $urandom);
    repeat (DEPTH + 2) idle_cycle();

    // Stray CDB
    bus.qry_tag1 = 4'd3;
    do_cdb(4'd3, 32'hDEAD);
    do_cdb(TAG_FREE, 32'hBEEF);
    idle_cycle();
    check("stray_qry_ready", bus.qry_ready1, 1'b0);

    // Async reset mid-run
    repeat (5) do_alloc(5'($urandom_range(31)));
    do_cdb(q[0].tag, 32'h77);
    idle_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_commit_en", bus.commit_en, 1'b0);
    check("arst_alloc_tag", bus.alloc_tag, 4'h0);
    check("arst_alloc_ready", bus.alloc_ready, 1'b1);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.qry_tag1 = 4'd1;
    do_cdb(4'd1, 32'h55);
    idle_cycle();
    check("arst_stale_cdb", bus.qry_ready1, 1'b0);

    // Query and bypass
    repeat (3) do_alloc(5'($urandom_range(31)));
    bus.qry_tag2 = 4'd2;
    do_cdb(4'd2, 32'hABCD);
    set_idle();
    #1;
    check("byp_next_ready", bus.qry_ready2, 1'b1);
    check("byp_next_data", bus.qry_data2, 32'hABCD);
    cycle();
    repeat (6) idle_cycle();

    // Randomized traffic
    repeat (400) begin
      bus.alloc_valid = ($urandom_range(99) < 60);
      bus.alloc_dest  = 5'($urandom_range(31));
      bus.cdb_valid   = ($urandom_range(99) < 50);
      bus.cdb_data    = $urandom;
      if (q.size() > 0 && $urandom_range(9) < 8) bus.cdb_tag = q[$urandom_range(q.size() - 1)].tag;
      else bus.cdb_tag = 4'($urandom_range(15));
      if (q.size() > 0 && $urandom_range(9) < 7) bus.qry_tag1 = q[$urandom_range(q.size() - 1)].tag;
      else bus.qry_tag1 = 4'($urandom_range(15));
      if (q.size() > 0 && $urandom_range(9) < 7) bus.qry_tag2 = q[$urandom_range(q.size() - 1)].tag;
      else bus.qry_tag2 = 4'($urandom_range(15));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer between decoder/dispatch, execution CDB and the register file.
- Allocates one tag per dispatched instruction and captures execution results by tag.
- Retires at most one completed entry per cycle in program order.
- The commit port drives the regfile write port directly: commit_en->enWrite, commit_name->namew, commit_data->dataw, commit_tag->tagw.

Parameters:
DEPTH, 8, number of entries; power of two, must be < 2**TAG_W
TAG_W, 4, tag width; tag = entry index
TAG_FREE, 4'hF, reserved "no producer" tag; never allocated
REG_W, 5, architectural register index width
DATA_W, 32, data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
alloc_valid  in  1  decoder requests an entry
alloc_ready  out  1  entry available (count < DEPTH)
alloc_dest  in  REG_W  destination register of allocated instruction
alloc_tag  out  TAG_W  tag granted this cycle (= tail index), combinational
cdb_valid  in  1  result broadcast valid
cdb_tag  in  TAG_W  producer tag of result
cdb_data  in  DATA_W  result value
qry_tag1/qry_tag2  in  TAG_W  operand tag lookup (two ports)
qry_ready1/qry_ready2  out  1  looked-up entry has its result
qry_data1/qry_data2  out  DATA_W  looked-up result, 0 when not ready
commit_en  out  1  retire strobe (registered)
commit_name  out  REG_W  retiring destination register
commit_data  out  DATA_W  retiring value
commit_tag  out  TAG_W  retiring entry tag

Behaviour:
- Reset: the async assertion of rst_n takes effect immediately and is not gated by clk.
  - All valid/ready bits clear; head=tail=0; count=0.
  - commit_en=0, commit_name=0, commit_data=0, commit_tag=TAG_FREE.
  - alloc_ready=1, alloc_tag=0.
- Entry fields: valid, ready, dest[REG_W], data[DATA_W].
- Allocate: fires when alloc_valid && alloc_ready.
  - On the edge: entry[tail] <= {valid=1, ready=0, dest=alloc_dest}; tail <= tail+1 mod DEPTH.
  - alloc_tag is always the tail index, even when no allocation fires.
- Write-back: when cdb_valid, cdb_tag != TAG_FREE, cdb_tag < DEPTH and entry[cdb_tag].valid:
  - Set ready=1 and store data.
  - Otherwise ignore silently, with no state change.
- Commit: evaluated on stored state.
  - If entry[head].valid && entry[head].ready, then on the edge: commit_en<=1; commit_name<=dest; commit_data<=data; commit_tag<=head; entry invalidated; head <= head+1 mod DEPTH.
  - Otherwise commit_en<=0; the other commit outputs hold their values.
- Latency: CDB sampled at edge E0, commit fires at E1, commit_en is high during the cycle after E1. A CDB write to the head entry never commits in the same edge.
- At most one commit per cycle. Back-to-back ready entries commit on consecutive cycles.
- Destination register 0 still commits; the regfile discards the write.
- Count: count <= count + alloc_fire - commit_fire.
- Full: alloc_ready is based on count at the start of the cycle, so when full, a same-cycle commit does not enable an allocation; allocation resumes the next cycle.
- Empty: no commit; head==tail.
- Pointer wrap: DEPTH-1 -> 0 for both head and tail.
- Query port: combinational.
  - If qry_tag selects a valid, ready entry: qry_ready=1, qry_data=data.
  - Otherwise qry_ready=0, qry_data=0; this includes qry_tag=TAG_FREE, a tag >= DEPTH, or an invalid entry.
- Simultaneous alloc + CDB + commit in one cycle touch independent entries; all three take effect.

Optional Feature:
ROB_QUERY_BYPASS_EN
- Defined: a query whose qry_tag matches an accepted CDB write in the same cycle returns qry_ready=1 and qry_data=cdb_data combinationally, ahead of storage.
- Undefined: queries reflect stored state only; the CDB value becomes visible one cycle later.

Test Plan:
- Reset: drive rst_n=0 then 1 -> commit_en=0, commit_tag=4'hF, alloc_ready=1, alloc_tag=0, qry_ready1=0.
- In-order retire: allocate dests 5,6,7 (tags 0,1,2); CDB tag1=0x22, then tag0=0x11 -> commit (r5,0x11,tag0), next cycle (r6,0x22,tag1); tag2 does not retire and commit_en drops.
- Full and wrap: allocate 8 entries -> alloc_ready=0 and a 9th request is ignored; complete and commit tag0 -> alloc_ready=1 the next cycle and the next alloc_tag wraps to 0 after tail wraps.
- Stray CDB: cdb_tag=3 with the entry unallocated, then cdb_tag=4'hF -> no state change, qry_ready for tag3=0, no commit.
- Query and bypass: CDB tag2 data 0xABCD while qry_tag2=2 -> same cycle qry_ready2=1 and data 0xABCD only with ROB_QUERY_BYPASS_EN; in both builds the next cycle reads 1/0xABCD.
- Async reset mid-run: 4 entries in flight, pull rst_n low between edges -> commit_en=0 and alloc_tag=0 immediately; after release, a CDB to old tag1 is ignored.
